demux6_reg: RTL and testbench
=============================

// Module: demux6_reg
// PURPOSE
//   Registered 1-to-6 result distributor: the write-side counterpart of the six-way select mux.
//   Accepts one DATA_WIDTH word plus a 3-bit destination code on a valid/ready input stream.
//   Holds the word in a single output register and presents it to exactly one of six consumers.
//   Sits between the RV64 execute result bus and per-unit write-back or forwarding sinks.
// PARAMETERS
//   DATA_WIDTH  64  width of the payload word
// PORTS
//   clk        in   1           single clock, rising edge
//   rst_n      in   1           asynchronous, active-low reset
//   flush      in   1           synchronous drop of the held entry
//   in_valid   in   1           input word valid
//   in_ready   out  1           block can accept the input word this cycle
//   in_sel     in   3           destination code: 0..5 valid; 6 and 7 are routed to port 0
//   in_data    in   DATA_WIDTH  payload word
//   out_valid  out  6           one-hot valid; bit i drives consumer i
//   out_ready  in   6           per-consumer ready
//   out_data   out  DATA_WIDTH  held payload, broadcast to all consumers
//   err_cnt    out  8           present only with DEMUX6_ERRCNT_EN
// BEHAVIOUR
//   - State: full_q (1b), sel_q (3b, always 0..5), data_q (DATA_WIDTH).
//     Two states: EMPTY (full_q=0) and FULL (full_q=1).
//   - Reset (rst_n low, async): full_q=0, sel_q=0, data_q=0.
//     Hence out_valid=6'b0, out_data=0 and in_ready=1 as soon as flush is 0.
//     A reset during FULL discards the held word with no handshake.
//   - Destination folding: eff_sel = (in_sel>5) ? 3'd0 : in_sel.
//     This mirrors the mux default-to-input-0 rule.
//   - Outputs:
//     out_valid[i] = full_q && (sel_q==i).
//     out_data = data_q, shown to all consumers; only the consumer with valid set takes it.
//   - drain = full_q && out_ready[sel_q]. Ready bits of consumers that are not selected are ignored.
//   - in_ready = !flush && (!full_q || drain). This is a combinational path from out_ready.
//   - load = in_valid && in_ready.
//   - Next state, in priority order:
//       flush          -> full_q<=0. Input is not accepted; sel_q and data_q are unchanged.
//       load           -> full_q<=1, sel_q<=eff_sel, data_q<=in_data.
//       drain && !load -> full_q<=0.
//       otherwise      -> hold.
//   - Latency and throughput:
//     Latency is 1 cycle: a word accepted on edge N is valid after edge N.
//     Throughput is 1 word per cycle when the selected consumer is always ready.
//     A simultaneous drain and load in FULL replaces the entry with no bubble.
//   - Back-pressure: while FULL with out_ready[sel_q]=0, out_valid and out_data stay stable.
//     in_ready stays 0 in this case.
//   - in_valid is ignored while in_ready=0. The producer holds in_data and in_sel until the handshake.
// CONFIGURATION
//   DEMUX6_ERRCNT_EN defined:
//     - err_cnt port exists; reset value 0.
//     - err_cnt increments by 1 on each load with in_sel>5.
//     - It saturates at 8'hFF and is not cleared by flush.
//   DEMUX6_ERRCNT_EN undefined:
//     - err_cnt port and counter are absent.
//     - Folding of codes 6 and 7 to port 0 is unchanged.
// TESTING
//   1. Reset: assert rst_n=0 mid-FULL -> out_valid=0 and out_data=0 immediately;
//      after release, in_ready=1.
//   2. Routing sweep: in_sel=0..5 with data 64'hA0..A5, all out_ready=1 ->
//      one-hot out_valid 6'b000001..6'b100000 one cycle later, data matching.
//   3. Back-pressure: load sel=3, data 64'hDEAD, out_ready=6'b110111 (bit 3 low) for 4 cycles ->
//      out_valid=6'b001000 held, in_ready=0;
//      then raise bit 3 -> drain, and a simultaneous new word is accepted in the same cycle.
//   4. Streaming: 16 back-to-back words alternating sel 1 and 4, all ready ->
//      16 outputs on 16 consecutive cycles, no bubbles.
//   5. Invalid code: in_sel=7, data 64'h55 -> out_valid=6'b000001;
//      with DEMUX6_ERRCNT_EN, err_cnt=1.
//      After 300 such loads, err_cnt=8'hFF.
//   6. Flush: FULL with sel=2 and flush=1 together with in_valid=1 ->
//      next cycle out_valid=0 and the input is not accepted (in_ready=0 during flush).

Source files
------------

// File: rtl/demux6_reg.sv
// demux6_reg: registered 1-to-6 result distributor.
// One payload word and a 3-bit destination code come in on a valid/ready
// stream. The word is held in a single output register and offered to exactly
// one of six consumers. Destination codes 6 and 7 fold onto consumer 0.
// Optional feature macro: DEMUX6_ERRCNT_EN adds err_cnt, a saturating count of
// loads that carried an out-of-range destination code.
module demux6_reg #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_sel,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [5:0]            out_valid,
    input  logic [5:0]            out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef DEMUX6_ERRCNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    // EMPTY / FULL encoding of full_q
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    // Codes above 5 have no consumer; they go to port 0, like the mux default.
    function automatic logic [2:0] fold_sel(input logic [2:0] sel);
        return (sel > 3'd5) ? 3'd0 : sel;
    endfunction

    // One-hot decode of a folded destination code (0..5).
    function automatic logic [5:0] sel_onehot(input logic [2:0] sel);
        logic [5:0] oh;
        oh = 6'b0;
        case (sel)
            3'd0:    oh = 6'b000001;
            3'd1:    oh = 6'b000010;
            3'd2:    oh = 6'b000100;
            3'd3:    oh = 6'b001000;
            3'd4:    oh = 6'b010000;
            3'd5:    oh = 6'b100000;
            default: oh = 6'b000001;
        endcase
        return oh;
    endfunction

    // Saturating increment for the 8-bit error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    logic                  full_q;
    logic [2:0]            sel_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic [2:0] eff_sel;
    logic [5:0] sel_oh;
    logic       drain;
    logic       load;

    // Output presentation and handshake terms; in_ready depends combinationally on out_ready.
    always_comb begin
        eff_sel   = fold_sel(in_sel);
        sel_oh    = sel_onehot(sel_q);
        out_valid = (full_q == ST_FULL) ? sel_oh : 6'b0;
        out_data  = data_q;
        // Only the selected consumer's ready bit matters; the others are masked off.
        drain     = |(out_valid & out_ready);
        in_ready  = !flush && (!full_q || drain);
        load      = in_valid && in_ready;
    end

    // Holding register: flush beats load, load beats drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= ST_EMPTY;
            sel_q  <= 3'd0;
            data_q <= '0;
        end else if (flush) begin
            full_q <= ST_EMPTY;
        end else if (load) begin
            full_q <= ST_FULL;
            sel_q  <= eff_sel;
            data_q <= in_data;
        end else if (drain) begin
            full_q <= ST_EMPTY;
        end
    end

`ifdef DEMUX6_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Count accepted words whose destination code had to be folded; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (load && (in_sel > 3'd5)) begin
            err_cnt_q <= sat_inc8(err_cnt_q);
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_demux6_reg.sv
// Directed testbench for demux6_reg. Inputs change 1 ns after a rising edge;
// registered outputs are observed in that same window, after the edge.
// Build with +define+DEMUX6_ERRCNT_EN to also exercise err_cnt.
`timescale 1ns/1ps
module tb_demux6_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [63:0] in_data;
    logic [5:0]  out_valid;
    logic [5:0]  out_ready;
    logic [63:0] out_data;
`ifdef DEMUX6_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux6_reg #(.DATA_WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX6_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = 3'd0;
        in_data = 64'd0; out_ready = 6'h3F;
        tick(); tick();
        checks++;
        if (out_valid !== 6'b0 || out_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h required valid=000000 data=0", out_valid, out_data);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        // Fill the register, then reset in the middle of the cycle.
        out_ready = 6'b0; in_valid = 1'b1; in_sel = 3'd2; in_data = 64'h1234;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 6'b000100 || out_data !== 64'h1234) begin
            errors++;
            $display("FAIL reset_prefill: valid=%b data=%h required 000100/1234", out_valid, out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 6'b0 || out_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_async: valid=%b data=%h required 000000/0", out_valid, out_data);
        end
        tick();
        rst_n = 1'b1; out_ready = 6'h3F;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 6'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b valid=%b required 1/000000", in_ready, out_valid);
        end
    endtask

    task automatic test_routing();
        logic [5:0] exp_v;
        out_ready = 6'h3F;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_sel = 3'(i); in_data = 64'hA0 + 64'(i);
            tick();
            exp_v = 6'b1 << i;
            checks++;
            if (out_valid !== exp_v || out_data !== (64'hA0 + 64'(i))) begin
                errors++;
                $display("FAIL route_%0d: valid=%b data=%h required %b/%h", i, out_valid, out_data, exp_v, 64'hA0 + 64'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 6'b0) begin
            errors++;
            $display("FAIL route_drain: valid=%b required 000000", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 6'b110111;
        in_valid = 1'b1; in_sel = 3'd3; in_data = 64'hDEAD;
        tick();
        in_sel = 3'd5; in_data = 64'hBEEF;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out_valid !== 6'b001000 || out_data !== 64'hDEAD || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b data=%h in_ready=%b required 001000/dead/0", c, out_valid, out_data, in_ready);
            end
            tick();
        end
        out_ready = 6'h3F;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 6'b100000 || out_data !== 64'hBEEF) begin
            errors++;
            $display("FAIL bp_replace: valid=%b data=%h required 100000/beef", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 6'b0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b required 000000", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int good;
        logic [5:0] exp_v;
        good = 0;
        out_ready = 6'h3F;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_sel = (k % 2 == 0) ? 3'd1 : 3'd4;
            in_data = 64'h100 + 64'(k);
            #1;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready_%0d: got %b required 1", k, in_ready);
            end
            tick();
            exp_v = (k % 2 == 0) ? 6'b000010 : 6'b010000;
            if (out_valid === exp_v && out_data === (64'h100 + 64'(k))) good++;
            else $display("FAIL stream_word_%0d: valid=%b data=%h required %b/%h", k, out_valid, out_data, exp_v, 64'h100 + 64'(k));
        end
        in_valid = 1'b0;
        checks++;
        if (good != 16) begin
            errors++;
            $display("FAIL stream_count: got %0d consecutive words required 16", good);
        end
        tick();
        checks++;
        if (out_valid !== 6'b0) begin
            errors++;
            $display("FAIL stream_empty: valid=%b required 000000", out_valid);
        end
    endtask

    task automatic test_invalid_code();
        out_ready = 6'h3F;
        in_valid = 1'b1; in_sel = 3'd7; in_data = 64'h55;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 6'b000001 || out_data !== 64'h55) begin
            errors++;
            $display("FAIL invalid_fold: valid=%b data=%h required 000001/55", out_valid, out_data);
        end
`ifdef DEMUX6_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL errcnt_one: got %0d required 1", err_cnt);
        end
`endif
        tick();
        // 299 more out-of-range loads, back to back, alternating 6 and 7.
        for (int k = 0; k < 299; k++) begin
            in_valid = 1'b1; in_sel = (k % 2 == 0) ? 3'd6 : 3'd7; in_data = 64'(k);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 6'b000001 || out_data !== 64'd298) begin
            errors++;
            $display("FAIL invalid_last: valid=%b data=%h required 000001/12a", out_valid, out_data);
        end
`ifdef DEMUX6_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL errcnt_sat: got %h required ff", err_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_flush();
        out_ready = 6'b0;
        in_valid = 1'b1; in_sel = 3'd2; in_data = 64'h22;
        tick();
        flush = 1'b1; in_sel = 3'd4; in_data = 64'h99;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b required 0", in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 6'b0 || out_data !== 64'h22) begin
            errors++;
            $display("FAIL flush_drop: valid=%b data=%h required 000000/22", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 6'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: valid=%b in_ready=%b required 000000/1", out_valid, in_ready);
        end
`ifdef DEMUX6_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL errcnt_flush: got %h required ff", err_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_back_to_back();
        test_invalid_code();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
